// File: rtl/cpu_pkg.sv
// Shared fetch-path types: instruction/address widths, fetch FSM states and the queued entry layout.
package cpu_pkg;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0;

  typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc4;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Generic first-word fall-through FIFO with synchronous clear; head reads 0 when empty.
// No internal overflow guard: the parent only pushes when a slot is guaranteed free.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = (count == '0) ? '0 : mem[rd_ptr];
endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: one outstanding imem request, responses queued as {pc+4, inst} toward IF/ID.
// First out_valid_o 2 cycles after start at zero-latency memory; FETCH_PERF_EN adds perf counters.
module inst_fetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   flush_i,
  input  logic [ADDR_W-1:0]      redirect_pc_i,
  output logic                   imem_req_o,
  output logic [ADDR_W-1:0]      imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [INST_W-1:0]      imem_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [INST_W-1:0]      out_inst_o,
  output logic [ADDR_W-1:0]      out_pc4_o,
`ifdef FETCH_PERF_EN
  output logic [31:0]            perf_fetch_o,
  output logic [31:0]            perf_drop_o,
`endif
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     count;
  logic [CW-1:0]     next_count;
  logic              ack;
  logic              push;
  logic              pop;
  logic              credit;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;

  assign ack        = imem_req_o & imem_ack_i;
  assign push       = ack & (state == REQ) & ~flush_i;
  assign pop        = out_valid_o & out_ready_i & ~flush_i;
  assign next_count = count + CW'(push) - CW'(pop);
  // A request is only launched if its response is certain to find a free slot.
  assign credit     = next_count < DEPTH_C;
  assign push_entry = '{pc4: imem_addr_o + 32'd4, inst: imem_data_i};

  fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .clr      (flush_i),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .head_dat (head),
    .count    (count)
  );

  assign out_valid_o = (count != '0);
  assign out_inst_o  = out_valid_o ? head.inst : NOP_INST;
  assign out_pc4_o   = out_valid_o ? head.pc4 : '0;
  assign count_o     = count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
    end else if (flush_i) begin
      // An unanswered request cannot be withdrawn: park in DROP until its ack.
      if (imem_req_o && !imem_ack_i) begin
        state    <= DROP;
        fetch_pc <= redirect_pc_i;
      end else if (start_i) begin
        state       <= REQ;
        imem_req_o  <= 1'b1;
        imem_addr_o <= redirect_pc_i;
        fetch_pc    <= redirect_pc_i + 32'd4;
      end else begin
        state      <= IDLE;
        imem_req_o <= 1'b0;
        fetch_pc   <= redirect_pc_i;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start_i && credit) begin
            state       <= REQ;
            imem_req_o  <= 1'b1;
            imem_addr_o <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
          end
        end
        REQ, DROP: begin
          if (ack) begin
            if (start_i && credit) begin
              state       <= REQ;
              imem_addr_o <= fetch_pc;
              fetch_pc    <= fetch_pc + 32'd4;
            end else begin
              state      <= IDLE;
              imem_req_o <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          imem_req_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetch_o <= '0;
      perf_drop_o  <= '0;
    end else begin
      if (push) perf_fetch_o <= perf_fetch_o + 32'd1;
      if (ack && (flush_i || state == DROP)) perf_drop_o <= perf_drop_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed vector table, multi-cycle corner sequences, random run vs. model.
module tb_inst_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, flush_i, imem_ack_i, out_ready_i;
  logic [31:0] redirect_pc_i, imem_data_i;
  logic        imem_req_o, out_valid_o;
  logic [31:0] imem_addr_o, out_inst_o, out_pc4_o;
  logic [2:0]  count_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_o, perf_drop_o;
`endif

  always #5 clk_i = ~clk_i;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_inst_o(out_inst_o), .out_pc4_o(out_pc4_o),
`ifdef FETCH_PERF_EN
    .perf_fetch_o(perf_fetch_o), .perf_drop_o(perf_drop_o),
`endif
    .count_o(count_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  int age = 0;
  int lat = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory answers a request once it has been outstanding for 'lat' cycles.
  task automatic drive_mem();
    imem_ack_i  = imem_req_o && (age >= lat);
    imem_data_i = imem_ack_i ? inst_of(imem_addr_o) : 32'hDEAD_BEEF;
  endtask

  task automatic tick();
    logic r, a;
    r = imem_req_o;
    a = imem_ack_i;
    @(posedge clk_i);
    #1;
    if (rst_i || (r && a)) age = 0;
    else if (r) age++;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    redirect_pc_i = 32'h0;
    drive_mem();
    tick();
    rst_i = 1'b0;
  endtask

  typedef struct {
    logic rst, start, ready, flush;
    logic [31:0] redir;
    logic req;
    logic [31:0] addr;
    logic valid;
    logic [31:0] pc4;
    logic [2:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic start, input logic ready,
                              input logic flush, input logic [31:0] redir, input logic req,
                              input logic [31:0] addr, input logic valid,
                              input logic [31:0] pc4, input logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.start = start; v.ready = ready; v.flush = flush; v.redir = redir;
    v.req = req; v.addr = addr; v.valid = valid; v.pc4 = pc4; v.cnt = cnt;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pop, exp_fetch, prev_addr;
    int m_cnt, pops, m_fetch, m_drop;
    bit stale, found, prev_req, prev_ack, was_rst, acc;

    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    redirect_pc_i = 32'h0; imem_ack_i = 1'b0; imem_data_i = 32'h0;
    tick();

    // Zero-latency streaming, backpressure to full, flush with ack, wrap, stop.
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,   3'd0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,   3'd0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h4,   3'd1);
    tbl[3]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h8,   3'd1);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         1'b1, 32'hC,   3'd1);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h10,        1'b1, 32'hC,   3'd2);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h14,        1'b1, 32'hC,   3'd3);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hC,   3'd4);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hC,   3'd4);
    tbl[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h18,        1'b1, 32'h10,  3'd3);
    tbl[10] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1C,        1'b1, 32'h14,  3'd3);
    tbl[11] = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h100,       1'b1, 32'h100,       1'b0, 32'h0,   3'd0);
    tbl[12] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h104,       1'b1, 32'h104, 3'd1);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,   3'd0);
    tbl[14] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'h0,   3'd1);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4,   3'd1);
    tbl[16] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,   3'd0);

    lat = 0;
    for (int i = 0; i < 17; i++) begin
      rst_i = tbl[i].rst; start_i = tbl[i].start; out_ready_i = tbl[i].ready;
      flush_i = tbl[i].flush; redirect_pc_i = tbl[i].redir;
      drive_mem();
      tick();
      chk($sformatf("vec%0d_req", i), 32'(imem_req_o), 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("vec%0d_addr", i), imem_addr_o, tbl[i].addr);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid_o), 32'(tbl[i].valid));
      chk($sformatf("vec%0d_pc4", i), out_pc4_o, tbl[i].pc4);
      chk($sformatf("vec%0d_inst", i), out_inst_o,
          tbl[i].valid ? inst_of(tbl[i].pc4 - 32'd4) : 32'h0);
      chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(tbl[i].cnt));
    end
    flush_i = 1'b0;

    // 3-cycle memory, flush one cycle after the request at 0x10 goes out.
    do_reset();
    lat = 3; start_i = 1'b1; out_ready_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (imem_req_o && imem_addr_o == 32'h10) found = 1'b1;
      else begin drive_mem(); tick(); end
    end
    chk("t3_reach_10", 32'(found), 32'd1);
    drive_mem(); tick();
    flush_i = 1'b1; redirect_pc_i = 32'h100;
    drive_mem(); tick();
    flush_i = 1'b0;
    chk("t3_drop_req", 32'(imem_req_o), 32'd1);
    chk("t3_drop_addr", imem_addr_o, 32'h10);
    chk("t3_flush_count", 32'(count_o), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive_mem(); tick();
      if (imem_req_o && imem_addr_o == 32'h100) found = 1'b1;
    end
    chk("t3_redirect_issue", 32'(found), 32'd1);
    chk("t3_no_stale_push", 32'(count_o), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid_o) found = 1'b1;
      else begin drive_mem(); tick(); end
    end
    chk("t3_first_valid", 32'(found), 32'd1);
    chk("t3_first_pc4", out_pc4_o, 32'h104);
    chk("t3_first_inst", out_inst_o, inst_of(32'h100));

    // Reset in the middle of a request with three entries queued; then a late ack.
    do_reset();
    lat = 2; start_i = 1'b1; out_ready_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (imem_req_o && count_o == 3'd3) found = 1'b1;
      else begin drive_mem(); tick(); end
    end
    chk("t5_reach_cnt3", 32'(found), 32'd1);
    rst_i = 1'b1;
    drive_mem(); tick();
    rst_i = 1'b0; start_i = 1'b0;
    chk("t5_rst_req", 32'(imem_req_o), 32'd0);
    chk("t5_rst_addr", imem_addr_o, RESET_PC);
    chk("t5_rst_valid", 32'(out_valid_o), 32'd0);
    chk("t5_rst_count", 32'(count_o), 32'd0);
    chk("t5_rst_pc4", out_pc4_o, 32'h0);
    chk("t5_rst_inst", out_inst_o, 32'h0);
    imem_ack_i = 1'b1; imem_data_i = 32'h1234_5678;
    tick();
    imem_ack_i = 1'b0;
    chk("t5_late_ack_count", 32'(count_o), 32'd0);
    chk("t5_late_ack_req", 32'(imem_req_o), 32'd0);

    // Random run against a transaction-level model: program-order PCs since the last redirect.
    do_reset();
    lat = 0; m_cnt = 0; pops = 0; stale = 1'b0; m_fetch = 0; m_drop = 0;
    exp_pop = RESET_PC; exp_fetch = RESET_PC;
    for (int c = 0; c < 3000; c++) begin
      rst_i         = ($urandom_range(0, 199) == 0);
      start_i       = ($urandom_range(0, 9) != 0);
      out_ready_i   = ($urandom_range(0, 9) < 7);
      flush_i       = ($urandom_range(0, 19) == 0);
      redirect_pc_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_0FFC);
      drive_mem();
      chk("rnd_count", 32'(count_o), 32'(m_cnt));
      chk("rnd_valid", 32'(out_valid_o), 32'(m_cnt != 0));
      chk("rnd_pc4", out_pc4_o, (m_cnt != 0) ? exp_pop + 32'd4 : 32'h0);
      chk("rnd_inst", out_inst_o, (m_cnt != 0) ? inst_of(exp_pop) : 32'h0);
      acc = imem_req_o && imem_ack_i;
      if (rst_i) begin
        m_cnt = 0; exp_pop = RESET_PC; exp_fetch = RESET_PC; stale = 1'b0;
        m_fetch = 0; m_drop = 0;
      end else if (flush_i) begin
        m_cnt = 0; exp_pop = redirect_pc_i; exp_fetch = redirect_pc_i;
        stale = imem_req_o && !imem_ack_i;
        if (acc) m_drop++;
      end else begin
        if (m_cnt != 0 && out_ready_i) begin
          m_cnt--; exp_pop += 32'd4; pops++;
        end
        if (acc) begin
          if (stale) begin
            stale = 1'b0; m_drop++;
          end else begin
            chk("rnd_fetch_addr", imem_addr_o, exp_fetch);
            exp_fetch += 32'd4; m_cnt++; m_fetch++;
          end
        end
      end
      prev_req = imem_req_o; prev_ack = imem_ack_i; prev_addr = imem_addr_o; was_rst = rst_i;
      tick();
      if (prev_req && prev_ack) lat = $urandom_range(0, 3);
      if (!was_rst && prev_req && !prev_ack) begin
        chk("rnd_req_hold", 32'(imem_req_o), 32'd1);
        chk("rnd_addr_hold", imem_addr_o, prev_addr);
      end
    end
    chk("rnd_progress", 32'(pops > 200), 32'd1);
`ifdef FETCH_PERF_EN
    chk("rnd_perf_fetch", perf_fetch_o, 32'(m_fetch));
    chk("rnd_perf_drop", perf_drop_o, 32'(m_drop));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
